// File: rtl/spart_pkg.sv
// Shared constants and serial state encoding for the SPART serial port.
package spart_pkg;

   localparam logic [1:0]  ADDR_BUF    = 2'b00;
   localparam logic [1:0]  ADDR_STAT   = 2'b01;
   localparam logic [1:0]  ADDR_DBL    = 2'b10;
   localparam logic [1:0]  ADDR_DBH    = 2'b11;

   localparam logic [15:0] DEFAULT_DIV = 16'h028B;
   localparam int          OVERSAMPLE  = 16;
   localparam int          MID_SAMPLE  = 8;

   // Terminal-count reload values for the per-bit tick down-counters.
   localparam logic [3:0]  OS_LAST     = 4'(OVERSAMPLE - 1);
   localparam logic [3:0]  MID_LAST    = 4'(MID_SAMPLE - 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_START = 2'b01,
      ST_DATA  = 2'b10,
      ST_STOP  = 2'b11
   } ser_state_e;

endpackage

// File: rtl/spart_if.sv
// Processor-side control/status bundle for the SPART; the data bus is a separate inout.
interface spart_if;

   logic       iocs;
   logic       iorw;
   logic [1:0] ioaddr;
   logic       rda;
   logic       tbr;

   modport master (output iocs, iorw, ioaddr, input rda, tbr);
   modport slave  (input iocs, iorw, ioaddr, output rda, tbr);

endinterface

// File: rtl/spart_rx.sv
// SPART receiver: rxd synchroniser, 16x-oversampled 8N1 FSM and single RX buffer.
//   state    | meaning
//   ST_IDLE  | line idle, waiting for a synchronised 1->0 edge
//   ST_START | counting to the start-bit mid-point, rejects glitches
//   ST_DATA  | sampling 8 data bits LSB first at bit mid-points
//   ST_STOP  | sampling stop bit; 1 stores the byte, 0 discards it
module spart_rx
   import spart_pkg::*;
#(
   parameter int SYNC_STAGES = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       tick,
   input  logic       rxd,
   input  logic       rd_clr,
   output logic [7:0] rx_data,
   output logic       rda
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   rx_s;
   logic                   rx_prev;
   ser_state_e             state;
   logic [3:0]             tick_cnt;
   logic [2:0]             bit_cnt;
   logic [7:0]             shift;

   assign rx_s = sync_q[SYNC_STAGES-1];

   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q   <= '1;
         rx_prev  <= 1'b1;
         state    <= ST_IDLE;
         tick_cnt <= '0;
         bit_cnt  <= '0;
         shift    <= '0;
         rx_data  <= '0;
         rda      <= 1'b0;
      end else begin
         sync_q  <= {sync_q[SYNC_STAGES-2:0], rxd};
         rx_prev <= rx_s;
         if (rd_clr)
            rda <= 1'b0;
         case (state)
            ST_IDLE: begin
               // A framing error parks here with the line low; no edge is
               // seen until the line has gone back high.
               if (rx_prev && !rx_s) begin
                  tick_cnt <= MID_LAST;
                  state    <= ST_START;
               end
            end
            ST_START: begin
               if (tick) begin
                  if (tick_cnt == 4'd0) begin
                     if (!rx_s) begin
                        tick_cnt <= OS_LAST;
                        bit_cnt  <= 3'd7;
                        state    <= ST_DATA;
                     end else begin
                        state <= ST_IDLE;
                     end
                  end else begin
                     tick_cnt <= tick_cnt - 4'd1;
                  end
               end
            end
            ST_DATA: begin
               if (tick) begin
                  if (tick_cnt == 4'd0) begin
                     shift    <= {rx_s, shift[7:1]};
                     tick_cnt <= OS_LAST;
                     if (bit_cnt == 3'd0)
                        state <= ST_STOP;
                     else
                        bit_cnt <= bit_cnt - 3'd1;
                  end else begin
                     tick_cnt <= tick_cnt - 4'd1;
                  end
               end
            end
            ST_STOP: begin
               if (tick) begin
                  if (tick_cnt == 4'd0) begin
                     // A new byte wins over a same-edge buffer read.
                     if (rx_s) begin
                        rx_data <= shift;
                        rda     <= 1'b1;
                     end
                     state <= ST_IDLE;
                  end else begin
                     tick_cnt <= tick_cnt - 4'd1;
                  end
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: rtl/spart.sv
// SPART slave: bus decode, programmable baud generator, 8N1 transmitter, receiver instance.
//   state    | meaning
//   ST_IDLE  | txd high, waiting for a byte in the TX buffer
//   ST_START | driving the start bit (0) for 16 ticks
//   ST_DATA  | shifting 8 data bits LSB first, 16 ticks each
//   ST_STOP  | driving the stop bit (1) for 16 ticks
module spart #(
   parameter logic [15:0] DEFAULT_DIV = spart_pkg::DEFAULT_DIV,
   parameter int          SYNC_STAGES = 2
) (
   input  logic       clk,
   input  logic       rst,
   spart_if.slave     bus,
   inout  wire  [7:0] databus,
   output logic       txd,
   input  logic       rxd
);

   import spart_pkg::*;

   logic [15:0] div_q;
   logic [15:0] baud_cnt;
   logic        tick;
   logic        bus_wr;
   logic        bus_rd;
   logic        rd_clr;
   logic        tx_load;
   logic [7:0]  rd_data;
   logic [7:0]  rx_data;
   logic        rda;
   logic        tbr_q;
   logic [7:0]  tx_buf;
   logic [7:0]  tx_shift;
   ser_state_e  tx_state;
   logic [3:0]  tx_tick_cnt;
   logic [2:0]  tx_bit_cnt;

   assign bus_wr  = bus.iocs & ~bus.iorw;
   assign bus_rd  = bus.iocs &  bus.iorw;
   assign rd_clr  = bus_rd && (bus.ioaddr == ADDR_BUF);
   assign tx_load = bus_wr && (bus.ioaddr == ADDR_BUF) && tbr_q;
   assign tick    = (baud_cnt == 16'd0);

   always_comb begin
      rd_data = 8'h00;
      case (bus.ioaddr)
         ADDR_BUF:  rd_data = rx_data;
         ADDR_STAT: rd_data = {6'b0, tbr_q, rda};
         ADDR_DBL:  rd_data = div_q[7:0];
         ADDR_DBH:  rd_data = div_q[15:8];
         default:   rd_data = 8'h00;
      endcase
   end

   assign databus = bus_rd ? rd_data : 8'hzz;
   assign bus.rda = rda;
   assign bus.tbr = tbr_q;

   // Divisor writes restart the baud phase so the new rate takes effect at once.
   always_ff @(posedge clk) begin
      if (rst) begin
         div_q    <= DEFAULT_DIV;
         baud_cnt <= DEFAULT_DIV;
      end else if (bus_wr && (bus.ioaddr == ADDR_DBL)) begin
         div_q[7:0] <= databus;
         baud_cnt   <= {div_q[15:8], databus};
      end else if (bus_wr && (bus.ioaddr == ADDR_DBH)) begin
         div_q[15:8] <= databus;
         baud_cnt    <= {databus, div_q[7:0]};
      end else if (tick) begin
         baud_cnt <= div_q;
      end else begin
         baud_cnt <= baud_cnt - 16'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         tx_state    <= ST_IDLE;
         txd         <= 1'b1;
         tbr_q       <= 1'b1;
         tx_buf      <= '0;
         tx_shift    <= '0;
         tx_tick_cnt <= '0;
         tx_bit_cnt  <= '0;
      end else begin
         case (tx_state)
            ST_IDLE: begin
               if (!tbr_q) begin
                  tx_shift    <= tx_buf;
                  tbr_q       <= 1'b1;
                  txd         <= 1'b0;
                  tx_tick_cnt <= OS_LAST;
                  tx_state    <= ST_START;
               end
            end
            ST_START: begin
               if (tick) begin
                  if (tx_tick_cnt == 4'd0) begin
                     txd         <= tx_shift[0];
                     tx_shift    <= tx_shift >> 1;
                     tx_bit_cnt  <= 3'd7;
                     tx_tick_cnt <= OS_LAST;
                     tx_state    <= ST_DATA;
                  end else begin
                     tx_tick_cnt <= tx_tick_cnt - 4'd1;
                  end
               end
            end
            ST_DATA: begin
               if (tick) begin
                  if (tx_tick_cnt == 4'd0) begin
                     tx_tick_cnt <= OS_LAST;
                     if (tx_bit_cnt == 3'd0) begin
                        txd      <= 1'b1;
                        tx_state <= ST_STOP;
                     end else begin
                        txd        <= tx_shift[0];
                        tx_shift   <= tx_shift >> 1;
                        tx_bit_cnt <= tx_bit_cnt - 3'd1;
                     end
                  end else begin
                     tx_tick_cnt <= tx_tick_cnt - 4'd1;
                  end
               end
            end
            ST_STOP: begin
               if (tick) begin
                  if (tx_tick_cnt == 4'd0) begin
                     // A byte buffered during the frame starts with no idle gap.
                     if (!tbr_q) begin
                        tx_shift    <= tx_buf;
                        tbr_q       <= 1'b1;
                        txd         <= 1'b0;
                        tx_tick_cnt <= OS_LAST;
                        tx_state    <= ST_START;
                     end else begin
                        tx_state <= ST_IDLE;
                     end
                  end else begin
                     tx_tick_cnt <= tx_tick_cnt - 4'd1;
                  end
               end
            end
            default: tx_state <= ST_IDLE;
         endcase
         // Loads only happen when the buffer is empty, so they never collide
         // with the buffer-to-shifter transfer above.
         if (tx_load) begin
            tx_buf <= databus;
            tbr_q  <= 1'b0;
         end
      end
   end

   spart_rx #(
      .SYNC_STAGES (SYNC_STAGES)
   ) u_rx (
      .clk     (clk),
      .rst     (rst),
      .tick    (tick),
      .rxd     (rxd),
      .rd_clr  (rd_clr),
      .rx_data (rx_data),
      .rda     (rda)
   );

endmodule

// File: tb/tb_spart.sv
// Self-checking bench for spart: bus access, 8N1 TX waveform model, RX model, reset.
`timescale 1ns/1ps
module tb_spart;
   import spart_pkg::*;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] tb_wdata;
   logic       tb_drv;
   logic       txd;
   logic       rxd_tb;
   logic       loop_en;
   wire        rxd_w;
   wire  [7:0] databus;

   int checks   = 0;
   int failures = 0;
   int cur_div  = 16'h028B;
   logic [7:0] last_good = 8'h00;

   always #5 clk = ~clk;

   spart_if bus ();

   assign databus = tb_drv ? tb_wdata : 8'hzz;
   for (genvar g = 0; g < 8; g++) begin : g_pu
      pullup (databus[g]);
   end
   assign rxd_w = loop_en ? txd : rxd_tb;

   spart #(
      .DEFAULT_DIV (16'h028B),
      .SYNC_STAGES (2)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .bus     (bus),
      .databus (databus),
      .txd     (txd),
      .rxd     (rxd_w)
   );

   task automatic bus_idle();
      bus.iocs   = 1'b0;
      bus.iorw   = 1'b0;
      bus.ioaddr = 2'b00;
      tb_drv     = 1'b0;
   endtask

   task automatic bus_write(input logic [1:0] addr, input logic [7:0] data);
      @(negedge clk);
      bus.iocs = 1'b1; bus.iorw = 1'b0; bus.ioaddr = addr;
      tb_wdata = data; tb_drv = 1'b1;
      @(negedge clk);
      bus_idle();
   endtask

   task automatic bus_read(input logic [1:0] addr, output logic [7:0] data);
      @(negedge clk);
      bus.iocs = 1'b1; bus.iorw = 1'b1; bus.ioaddr = addr;
      #1 data = databus;
      @(negedge clk);
      bus_idle();
   endtask

   task automatic set_div(input logic [15:0] d);
      bus_write(ADDR_DBH, d[15:8]);
      bus_write(ADDR_DBL, d[7:0]);
      cur_div = int'(d);
   endtask

   // Ideal 8N1 line level i cycles after the load edge, for start-bit length L.
   function automatic logic exp_tx(int i, int L, int P, logic [7:0] b);
      int k;
      if (i < 1)     return 1'b1;
      if (i < 1 + L) return 1'b0;
      k = (i - 1 - L) / P;
      if (k < 8)     return b[k];
      return 1'b1;
   endfunction

   task automatic wait_rda(input int limit);
      for (int c = 0; c < limit && bus.rda !== 1'b1; c++) @(negedge clk);
   endtask

   task automatic send_serial(input logic [7:0] b, input logic stop);
      int P;
      P = 16 * (cur_div + 1);
      rxd_tb = 1'b0;
      repeat (P) @(negedge clk);
      for (int k = 0; k < 8; k++) begin
         rxd_tb = b[k];
         repeat (P) @(negedge clk);
      end
      rxd_tb = stop;
      repeat (P) @(negedge clk);
      rxd_tb = 1'b1;
      repeat (3) @(negedge clk);
   endtask

   // Sends one byte and checks the whole frame; dbl repeats the write on the next cycle.
   task automatic tx_frame(input logic [7:0] b, input bit dbl);
      logic wave [0:1023];
      logic tbr1;
      int   P, n, bad_i, idle_bad;
      bit   ok, m;
      P = 16 * (cur_div + 1);
      n = 10 * P + 4;
      checks++;
      if (bus.tbr !== 1'b1) begin
         failures++;
         $display("FAIL tx_tbr_pre data=%h: tbr=%b want 1", b, bus.tbr);
      end
      @(negedge clk);
      bus.iocs = 1'b1; bus.iorw = 1'b0; bus.ioaddr = ADDR_BUF;
      tb_wdata = b; tb_drv = 1'b1;
      @(negedge clk);
      checks++;
      if (bus.tbr !== 1'b0) begin
         failures++;
         $display("FAIL tx_tbr_load data=%h: tbr=%b want 0", b, bus.tbr);
      end
      tbr1 = 1'b0;
      for (int i = 0; i < n; i++) begin
         wave[i] = txd;
         if (i == 1) tbr1 = bus.tbr;
         if ((i == 0 && !dbl) || i == 1) bus_idle();
         @(negedge clk);
      end
      checks++;
      if (tbr1 !== 1'b1) begin
         failures++;
         $display("FAIL tx_tbr_start data=%h: tbr=%b want 1", b, tbr1);
      end
      ok = 1'b0;
      for (int L = P - cur_div; L <= P; L++) begin
         m = 1'b1;
         for (int i = 0; i < n; i++) if (wave[i] !== exp_tx(i, L, P, b)) m = 1'b0;
         if (m) ok = 1'b1;
      end
      checks++;
      if (!ok) begin
         failures++;
         bad_i = -1;
         for (int i = n - 1; i >= 0; i--) if (wave[i] !== exp_tx(i, P, P, b)) bad_i = i;
         $display("FAIL tx_frame data=%h div=%0d: txd at cycle %0d is %b, want %b (no start length %0d..%0d fits)",
                  b, cur_div, bad_i, (bad_i >= 0) ? wave[bad_i] : 1'b1,
                  (bad_i >= 0) ? exp_tx(bad_i, P, P, b) : 1'b1, P - cur_div, P);
      end
      idle_bad = 0;
      for (int i = 0; i < 2 * P; i++) begin
         if (txd !== 1'b1 || bus.tbr !== 1'b1) idle_bad++;
         @(negedge clk);
      end
      checks++;
      if (idle_bad != 0) begin
         failures++;
         $display("FAIL tx_idle_after data=%h: %0d non-idle cycles, want 0", b, idle_bad);
      end
   endtask

   task automatic test_reset();
      logic [7:0] d;
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      checks++;
      if ({txd, bus.tbr, bus.rda} !== 3'b110) begin
         failures++;
         $display("FAIL reset_outputs: txd,tbr,rda=%b want 110", {txd, bus.tbr, bus.rda});
      end
      bus.iocs = 1'b0; bus.iorw = 1'b1; bus.ioaddr = ADDR_DBL;
      #1;
      checks++;
      if (databus !== 8'hFF) begin
         failures++;
         $display("FAIL bus_float_cs0: databus=%h want ff (undriven)", databus);
      end
      bus_idle();
      bus_read(ADDR_DBL, d);
      checks++;
      if (d !== 8'h8B) begin failures++; $display("FAIL reset_dbl: got %h want 8b", d); end
      bus_read(ADDR_DBH, d);
      checks++;
      if (d !== 8'h02) begin failures++; $display("FAIL reset_dbh: got %h want 02", d); end
      bus_read(ADDR_STAT, d);
      checks++;
      if (d !== 8'h02) begin failures++; $display("FAIL reset_stat: got %h want 02", d); end
      bus_read(ADDR_BUF, d);
      checks++;
      if (d !== 8'h00) begin failures++; $display("FAIL reset_rxbuf: got %h want 00", d); end
   endtask

   task automatic test_divisor();
      logic [7:0] d;
      set_div(16'h0003);
      bus_read(ADDR_DBL, d);
      checks++;
      if (d !== 8'h03) begin failures++; $display("FAIL div_dbl: got %h want 03", d); end
      bus_read(ADDR_DBH, d);
      checks++;
      if (d !== 8'h00) begin failures++; $display("FAIL div_dbh: got %h want 00", d); end
      bus_write(ADDR_STAT, 8'hFF);
      bus_read(ADDR_STAT, d);
      checks++;
      if (d !== 8'h02) begin failures++; $display("FAIL stat_write_ignored: got %h want 02", d); end
      tx_frame(8'hA5, 1'b0);
   endtask

   task automatic test_back_to_back();
      tx_frame(8'h55, 1'b1);
   endtask

   task automatic test_tx_random();
      for (int r = 0; r < 4; r++) begin
         set_div(16'($urandom_range(0, 3)));
         tx_frame(8'($urandom), 1'b0);
      end
   endtask

   task automatic test_rx_loopback();
      logic [7:0] b, d;
      int P;
      set_div(16'h0003);
      P = 16 * (cur_div + 1);
      loop_en = 1'b1;
      for (int r = 0; r < 3; r++) begin
         b = (r == 0) ? 8'h3C : 8'($urandom);
         bus_write(ADDR_BUF, b);
         wait_rda(12 * P);
         checks++;
         if (bus.rda !== 1'b1) begin failures++; $display("FAIL rx_loop_rda data=%h: rda=%b want 1", b, bus.rda); end
         bus_read(ADDR_STAT, d);
         checks++;
         if (d !== 8'h03) begin failures++; $display("FAIL rx_loop_stat: got %h want 03", d); end
         bus_read(ADDR_BUF, d);
         checks++;
         if (d !== b) begin failures++; $display("FAIL rx_loop_data: got %h want %h", d, b); end
         checks++;
         if (bus.rda !== 1'b0) begin failures++; $display("FAIL rx_loop_clr: rda=%b want 0", bus.rda); end
         last_good = b;
         repeat (P) @(negedge clk);
      end
      loop_en = 1'b0;
   endtask

   task automatic test_rx_errors();
      logic [7:0] b, d;
      int P, hits;
      P = 16 * (cur_div + 1);
      rxd_tb = 1'b0;
      repeat (20) @(negedge clk);
      rxd_tb = 1'b1;
      hits = 0;
      for (int i = 0; i < 11 * P; i++) begin
         if (bus.rda !== 1'b0) hits++;
         @(negedge clk);
      end
      checks++;
      if (hits != 0) begin failures++; $display("FAIL rx_glitch: rda high %0d cycles, want 0", hits); end
      send_serial(8'($urandom), 1'b0);
      checks++;
      if (bus.rda !== 1'b0) begin failures++; $display("FAIL rx_frame_err_rda: rda=%b want 0", bus.rda); end
      bus_read(ADDR_BUF, d);
      checks++;
      if (d !== last_good) begin failures++; $display("FAIL rx_frame_err_buf: got %h want %h", d, last_good); end
      b = 8'($urandom);
      send_serial(b, 1'b1);
      checks++;
      if (bus.rda !== 1'b1) begin failures++; $display("FAIL rx_rearm_rda data=%h: rda=%b want 1", b, bus.rda); end
      send_serial(8'h77, 1'b1);
      checks++;
      if (bus.rda !== 1'b1) begin failures++; $display("FAIL rx_overwrite_rda: rda=%b want 1", bus.rda); end
      bus_read(ADDR_BUF, d);
      checks++;
      if (d !== 8'h77) begin failures++; $display("FAIL rx_overwrite_data: got %h want 77", d); end
      checks++;
      if (bus.rda !== 1'b0) begin failures++; $display("FAIL rx_overwrite_clr: rda=%b want 0", bus.rda); end
   endtask

   task automatic test_reset_midframe();
      logic [7:0] d;
      int P, falls;
      set_div(16'h0003);
      P = 16 * (cur_div + 1);
      bus_write(ADDR_BUF, 8'($urandom));
      repeat (1 + 4 * P + P / 2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      checks++;
      if ({txd, bus.tbr, bus.rda} !== 3'b110) begin
         failures++;
         $display("FAIL reset_mid_outputs: txd,tbr,rda=%b want 110", {txd, bus.tbr, bus.rda});
      end
      falls = 0;
      for (int i = 0; i < 2000; i++) begin
         if (txd !== 1'b1) falls++;
         @(negedge clk);
      end
      checks++;
      if (falls != 0) begin failures++; $display("FAIL reset_mid_quiet: txd low %0d cycles, want 0", falls); end
      bus_read(ADDR_DBL, d);
      checks++;
      if (d !== 8'h8B) begin failures++; $display("FAIL reset_mid_div: got %h want 8b", d); end
   endtask

   initial begin
      rst     = 1'b1;
      rxd_tb  = 1'b1;
      loop_en = 1'b0;
      tb_wdata = 8'h00;
      bus_idle();
      test_reset();
      test_divisor();
      test_back_to_back();
      test_tx_random();
      test_rx_loopback();
      test_rx_errors();
      test_reset_midframe();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
